traffic_light_fsm: RTL and testbench

//  Moore FSM controller for a two-road intersection: main road (North/South) and side road (East/West).

---
 rtl/traffic_light_pkg.sv | 35 +++
 rtl/traffic_light_fsm.sv | 95 +++++++++
 tb/tb_traffic_light_fsm.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/traffic_light_pkg.sv
// Shared encodings for the two-road intersection controller: state codes and
// lamp patterns ({N,S,E,W}, each {R,Y,G}).
package traffic_light_pkg;

   typedef enum logic [2:0] {
      ST_MAIN_GREEN = 3'b000,
      ST_MAIN_YEL   = 3'b001,
      ST_AR_MS      = 3'b010,
      ST_SIDE_GREEN = 3'b011,
      ST_SIDE_YEL   = 3'b100,
      ST_AR_SM      = 3'b101,
      ST_EMERG      = 3'b110,
      ST_ILLEGAL    = 3'b111
   } state_e;

   localparam logic [11:0] LIGHTS_MAIN_GREEN = 12'h264;
   localparam logic [11:0] LIGHTS_MAIN_YEL   = 12'h4A4;
   localparam logic [11:0] LIGHTS_ALL_RED    = 12'h924;
   localparam logic [11:0] LIGHTS_SIDE_GREEN = 12'h909;
   localparam logic [11:0] LIGHTS_SIDE_YEL   = 12'h912;

   // Anything not explicitly a go/caution state shows all-red, including 111.
   function automatic logic [11:0] decode_lights(input state_e st);
      logic [11:0] l;
      case (st)
         ST_MAIN_GREEN: l = LIGHTS_MAIN_GREEN;
         ST_MAIN_YEL:   l = LIGHTS_MAIN_YEL;
         ST_SIDE_GREEN: l = LIGHTS_SIDE_GREEN;
         ST_SIDE_YEL:   l = LIGHTS_SIDE_YEL;
         default:       l = LIGHTS_ALL_RED;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/traffic_light_fsm.sv
// Moore controller: main road rests green, side-road requests cycle through
// side green, emergency preempts to a held all-red.
module traffic_light_fsm
   import traffic_light_pkg::*;
#(
   parameter int unsigned MIN_GREEN   = 3,
   parameter int unsigned YELLOW_CYC  = 2,
   parameter int unsigned ALL_RED_CYC = 1,
   parameter int unsigned SIDE_GREEN  = 4,
   parameter int unsigned CNT_W       = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        V,
   input  logic        Z,
   output logic [2:0]  present_state,
   output logic [2:0]  next_state,
   output logic [11:0] lights
);

   // done(N) is cnt >= N-1; the last-count values fit because N <= 2**CNT_W.
   localparam logic [CNT_W-1:0] MG_LAST  = CNT_W'(MIN_GREEN - 32'd1);
   localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_CYC - 32'd1);
   localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALL_RED_CYC - 32'd1);
   localparam logic [CNT_W-1:0] SG_LAST  = CNT_W'(SIDE_GREEN - 32'd1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_r;
   state_e           next_s;
   logic [CNT_W-1:0] cnt_r;

   // Next-state selection; Z wins over V wherever both matter.
   always_comb begin
      next_s = state_r;
      case (state_r)
         ST_MAIN_GREEN: begin
            if (Z) begin
               next_s = ST_MAIN_YEL;
            end else if (V && (cnt_r >= MG_LAST)) begin
               next_s = ST_MAIN_YEL;
            end else begin
               next_s = ST_MAIN_GREEN;
            end
         end
         ST_MAIN_YEL: begin
            if (cnt_r >= YEL_LAST) next_s = ST_AR_MS;
            else                   next_s = ST_MAIN_YEL;
         end
         ST_AR_MS: begin
            if (cnt_r >= AR_LAST) next_s = Z ? ST_EMERG : ST_SIDE_GREEN;
            else                  next_s = ST_AR_MS;
         end
         ST_SIDE_GREEN: begin
            if (Z || (cnt_r >= SG_LAST)) next_s = ST_SIDE_YEL;
            else                         next_s = ST_SIDE_GREEN;
         end
         ST_SIDE_YEL: begin
            if (cnt_r >= YEL_LAST) next_s = ST_AR_SM;
            else                   next_s = ST_SIDE_YEL;
         end
         ST_AR_SM: begin
            if (cnt_r >= AR_LAST) next_s = Z ? ST_EMERG : ST_MAIN_GREEN;
            else                  next_s = ST_AR_SM;
         end
         ST_EMERG: begin
            if (Z) next_s = ST_EMERG;
            else   next_s = ST_AR_SM;
         end
         default: next_s = ST_AR_SM;
      endcase
   end

   // State register and dwell counter (cleared on any state change, saturating).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_MAIN_GREEN;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= next_s;
         if (next_s != state_r) begin
            cnt_r <= {CNT_W{1'b0}};
         end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   assign present_state = state_r;
   assign next_state    = next_s;
   assign lights        = decode_lights(state_r);

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm: hand-computed state/next/lights per cycle.
module tb_traffic_light_fsm;

   logic        clk;
   logic        rst_n;
   logic        V;
   logic        Z;
   logic [2:0]  present_state;
   logic [2:0]  next_state;
   logic [11:0] lights;

   int pass_cnt = 0;
   int total_cnt = 0;

   traffic_light_fsm dut (
      .clk(clk),
      .rst_n(rst_n),
      .V(V),
      .Z(Z),
      .present_state(present_state),
      .next_state(next_state),
      .lights(lights)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Check current cycle at the falling edge, then advance to just after the next rising edge.
   task automatic tick(input string tag, input logic [2:0] st, input logic [2:0] nx,
                       input logic [11:0] lt);
      @(negedge clk);
      chk({tag, ".state"}, {9'd0, present_state}, {9'd0, st});
      chk({tag, ".next"}, {9'd0, next_state}, {9'd0, nx});
      chk({tag, ".lights"}, lights, lt);
      @(posedge clk);
      #1;
   endtask

   // Short reset pulse between edges; the following cycle starts at cnt=0.
   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      V = 1'b0;
      Z = 1'b0;
      #2;
      chk("rst.state", {9'd0, present_state}, 12'h000);
      chk("rst.lights", lights, 12'h264);
      #5;
      rst_n = 1'b1;

      // 1: idle rests in main green
      for (int i = 0; i < 10; i++) tick("idle", 3'b000, 3'b000, 12'h264);

      // 2: V held -> full side cycle, V ignored during side green
      do_reset();
      V = 1'b1;
      tick("v.mg0", 3'b000, 3'b000, 12'h264);
      tick("v.mg1", 3'b000, 3'b000, 12'h264);
      tick("v.mg2", 3'b000, 3'b001, 12'h264);
      tick("v.my0", 3'b001, 3'b001, 12'h4A4);
      tick("v.my1", 3'b001, 3'b010, 12'h4A4);
      tick("v.arms", 3'b010, 3'b011, 12'h924);
      tick("v.sg0", 3'b011, 3'b011, 12'h909);
      tick("v.sg1", 3'b011, 3'b011, 12'h909);
      tick("v.sg2", 3'b011, 3'b011, 12'h909);
      tick("v.sg3", 3'b011, 3'b100, 12'h909);
      tick("v.sy0", 3'b100, 3'b100, 12'h912);
      tick("v.sy1", 3'b100, 3'b101, 12'h912);
      tick("v.arsm", 3'b101, 3'b000, 12'h924);
      tick("v.back", 3'b000, 3'b000, 12'h264);
      V = 1'b0;

      // 3: V pulse at cnt=0 is lost
      do_reset();
      V = 1'b1;
      tick("vp.0", 3'b000, 3'b000, 12'h264);
      V = 1'b0;
      for (int i = 0; i < 3; i++) tick("vp.n", 3'b000, 3'b000, 12'h264);

      // 4: emergency from main green, held, then recovery
      do_reset();
      Z = 1'b1;
      tick("z.mg", 3'b000, 3'b001, 12'h264);
      tick("z.my0", 3'b001, 3'b001, 12'h4A4);
      tick("z.my1", 3'b001, 3'b010, 12'h4A4);
      tick("z.arms", 3'b010, 3'b110, 12'h924);
      for (int i = 0; i < 3; i++) tick("z.em", 3'b110, 3'b110, 12'h924);
      Z = 1'b0;
      tick("z.emx", 3'b110, 3'b101, 12'h924);
      tick("z.arsm", 3'b101, 3'b000, 12'h264 ^ 12'h264 ^ 12'h924);
      tick("z.mg2", 3'b000, 3'b000, 12'h264);

      // 5: emergency during side green at cnt=1
      do_reset();
      V = 1'b1;
      tick("zs.mg0", 3'b000, 3'b000, 12'h264);
      tick("zs.mg1", 3'b000, 3'b000, 12'h264);
      tick("zs.mg2", 3'b000, 3'b001, 12'h264);
      tick("zs.my0", 3'b001, 3'b001, 12'h4A4);
      tick("zs.my1", 3'b001, 3'b010, 12'h4A4);
      tick("zs.arms", 3'b010, 3'b011, 12'h924);
      V = 1'b0;
      tick("zs.sg0", 3'b011, 3'b011, 12'h909);
      Z = 1'b1;
      tick("zs.sg1", 3'b011, 3'b100, 12'h909);
      tick("zs.sy0", 3'b100, 3'b100, 12'h912);
      tick("zs.sy1", 3'b100, 3'b101, 12'h912);
      tick("zs.arsm", 3'b101, 3'b110, 12'h924);
      tick("zs.em", 3'b110, 3'b110, 12'h924);
      Z = 1'b0;
      tick("zs.emx", 3'b110, 3'b101, 12'h924);
      tick("zs.arsm2", 3'b101, 3'b000, 12'h924);

      // 6: async reset mid side green, then full MIN_GREEN again
      do_reset();
      V = 1'b1;
      tick("ar.mg0", 3'b000, 3'b000, 12'h264);
      tick("ar.mg1", 3'b000, 3'b000, 12'h264);
      tick("ar.mg2", 3'b000, 3'b001, 12'h264);
      tick("ar.my0", 3'b001, 3'b001, 12'h4A4);
      tick("ar.my1", 3'b001, 3'b010, 12'h4A4);
      tick("ar.arms", 3'b010, 3'b011, 12'h924);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar.async.state", {9'd0, present_state}, 12'h000);
      chk("ar.async.lights", lights, 12'h264);
      rst_n = 1'b1;
      tick("ar.mg0b", 3'b000, 3'b000, 12'h264);
      tick("ar.mg1b", 3'b000, 3'b000, 12'h264);
      tick("ar.mg2b", 3'b000, 3'b001, 12'h264);
      V = 1'b0;

      // Illegal code decodes all-red and recovers through AR_SM
      force dut.state_r = traffic_light_pkg::ST_ILLEGAL;
      #1;
      chk("ill.lights", lights, 12'h924);
      chk("ill.next", {9'd0, next_state}, 12'h005);
      @(negedge clk);
      release dut.state_r;
      @(posedge clk);
      #1;
      tick("ill.arsm", 3'b101, 3'b000, 12'h924);
      tick("ill.mg", 3'b000, 3'b000, 12'h264);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #100000;
      $fatal(1, "FAIL timeout: simulation did not finish");
   end

endmodule
